// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory-side blocks.
// Holds the data-memory responder state encoding and the data-memory base address.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the data-memory responder, DEPTH_WORDS x 32, no reset.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the caller sequences all accesses.
module data_mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Slow data-memory model behind the MEM stage: one load/store per transaction.
// Latency: ready low for WAIT_CYCLES+1 cycles, load data valid in the DONE cycle.
// Backpressure: ready drops combinationally on acceptance and stays low through BUSY.
module data_mem_responder
    import arm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] ADDR_BASE   = DATA_MEM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    mem_state_e    r_state;
    mem_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_op_wr;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rd_data;

    logic          w_req;
    logic          w_accept;
    logic          w_finish;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;

    assign w_req = rd_en | wr_en;
    // Base-relative word index; high bits drop so out-of-range addresses wrap.
    assign w_idx = AW'((address - ADDR_BASE) >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b1;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    ready       = 1'b0;
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                ready = 1'b0;
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            // A request still asserted here is the one just served.
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_op_wr   <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_op_wr <= wr_en;
                r_idx   <= w_idx;
                r_wdata <= wr_data;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish && !r_op_wr) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign w_we    = w_finish & r_op_wr;
    assign rd_data = r_rd_data;

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rd_word)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with default parameters.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .address (address),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ready   (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one request from an IDLE cycle, counts ready-low cycles up to DONE,
    // and returns rd_data sampled in DONE. Optionally alters address/data in BUSY.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic chg,
                       input logic [31:0] caddr, input logic [31:0] cdata,
                       output int stall, output logic [31:0] rdat);
        @(posedge clk); #1;
        rd_en   = rd;
        wr_en   = wr;
        address = addr;
        wr_data = data;
        stall   = 0;
        rdat    = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                rdat = rd_data;
                break;
            end
            stall++;
            if (chg && i == 0) begin
                @(posedge clk); #1;
                address = caddr;
                wr_data = cdata;
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    int          st;
    logic [31:0] rv;

    initial begin
        rst     = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        address = 32'd0;
        wr_data = 32'd0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, ready}, 32'd1);
            chk("rst_rdata", rd_data, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, ready}, 32'd1);
            chk("idle_rdata", rd_data, 32'd0);
        end

        // Write then read back at the base address.
        txn(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, 0, 0, st, rv);
        chk("wr_stall", st, 32'd5);
        chk("wr_keeps_rdata", rv, 32'd0);
        txn(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 0, 0, st, rv);
        chk("rd_stall", st, 32'd5);
        chk("rd_data_beef", rv, 32'hDEAD_BEEF);

        // Index wrap and ignored byte offset.
        txn(1'b0, 1'b1, 32'd1280, 32'h11, 1'b0, 0, 0, st, rv);
        txn(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 0, 0, st, rv);
        chk("wrap_rd", rv, 32'h11);
        txn(1'b1, 1'b0, 32'd1027, 32'd0, 1'b0, 0, 0, st, rv);
        chk("misalign_rd", rv, 32'h11);

        // Both enables act as a write and leave rd_data alone.
        txn(1'b0, 1'b1, 32'd1032, 32'h55, 1'b0, 0, 0, st, rv);
        txn(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 0, 0, st, rv);
        chk("pre_both_rd", rv, 32'h55);
        txn(1'b1, 1'b1, 32'd1032, 32'hAA, 1'b0, 0, 0, st, rv);
        chk("both_stall", st, 32'd5);
        chk("both_rdata_hold", rv, 32'h55);
        @(negedge clk);
        chk("both_rdata_after", rd_data, 32'h55);
        txn(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 0, 0, st, rv);
        chk("both_wrote", rv, 32'hAA);

        // Inputs altered during BUSY must not affect the captured write.
        txn(1'b0, 1'b1, 32'd1044, 32'h4444, 1'b0, 0, 0, st, rv);
        txn(1'b0, 1'b1, 32'd1040, 32'h1234_5678, 1'b1, 32'd1044, 32'h9999, st, rv);
        chk("chg_stall", st, 32'd5);
        txn(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 0, 0, st, rv);
        chk("chg_captured", rv, 32'h1234_5678);
        txn(1'b1, 1'b0, 32'd1044, 32'd0, 1'b0, 0, 0, st, rv);
        chk("chg_untouched", rv, 32'h4444);

        // Reset in the second BUSY cycle abandons the write.
        txn(1'b0, 1'b1, 32'd1036, 32'h36, 1'b0, 0, 0, st, rv);
        txn(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 0, 0, st, rv);
        chk("pre_rst_rd", rv, 32'h36);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        address = 32'd1036;
        wr_data = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rst   = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_rdata", rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        txn(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 0, 0, st, rv);
        chk("rst_abandon", rv, 32'h36);
        chk("post_rst_stall", st, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder on the far side of the MEM stage's load/store request interface. It accepts one read or write per transaction from the pipeline (`rd_en`/`wr_en`, address, store data) and models a slow memory with a fixed number of wait cycles. It drives `ready` low while a transaction is outstanding so the top level can feed `~ready` into the pipeline freeze. It returns load data registered on completion.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words in the array. Must be a power of two.
- `WAIT_CYCLES`, default 4: number of BUSY cycles per transaction. Must be ≥1.
- `ADDR_BASE`, default 1024: byte address that maps to word 0.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `rd_en`  in  1: load request from the MEM stage.
- `wr_en`  in  1: store request from the MEM stage.
- `address`  in  32: byte address (ALU result).
- `wr_data`  in  32: store data (Rm value).
- `rd_data`  out  32: load result. Valid when `ready`=1 after a read completes.
- `ready`  out  1: 0 while a transaction is pending. The top level uses it as the pipeline freeze/stall.

## Operation
- Word index = `(address - ADDR_BASE) >> 2`, truncated to log2(`DEPTH_WORDS`) bits.
  - Out-of-range addresses wrap modulo `DEPTH_WORDS`.
  - `address[1:0]` is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - With `rd_en|wr_en`=1: capture op, index and `wr_data`; load the counter with `WAIT_CYCLES-1`; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - While the counter is nonzero, decrement it.
  - When the counter is 0:
    - For a write, write the captured data into the array.
    - For a read, register the array word into `rd_data`.
    - Go to DONE.
- DONE: go to IDLE unconditionally. A request present in this cycle is the already-served one and is not re-accepted.
- `ready` is combinational:
  - 0 in IDLE when `rd_en|wr_en`=1.
  - 0 in BUSY.
  - 1 otherwise.
- `rd_en` and `wr_en` both high: treated as a write; `rd_data` is unchanged.
- Request inputs dropped or changed during BUSY: the transaction completes using the captured values. Inputs are sampled only at acceptance.
- `rd_data` holds its value until the next read completes. Writes and idle cycles do not alter it.

## Timing
- Reset values:
  - state = IDLE, counter = 0, `rd_data` = 0.
  - `ready` = 1 (with no request present).
  - Array contents are not cleared.
- Request first seen in cycle 0:
  - `ready` is low for cycles 0 through `WAIT_CYCLES`.
  - `ready` is high in cycle `WAIT_CYCLES+1` (DONE), with `rd_data` valid in that cycle.
  - Total stall = `WAIT_CYCLES+1` cycles.
- Array write occurs at the clock edge ending cycle `WAIT_CYCLES`.
- Back-to-back requests: the next request can be accepted in IDLE the cycle after DONE. Issue interval = `WAIT_CYCLES+2` cycles.
- Reset asserted mid-BUSY:
  - Immediate return to IDLE, `rd_data` = 0.
  - A pending write is abandoned; the array is not modified.

## Structure
- Shared package `arm_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - the `DATA_MEM_BASE` constant (1024) used as the default for `ADDR_BASE`.
- One sub-module, `data_mem_array`: synchronous-write, asynchronous-read `DEPTH_WORDS`×32 storage, no reset.
- The FSM, counter and address translation live in the top module.

## Test plan
- **Reset value:** with `rst`=0, then released and no request → `ready`=1 and `rd_data`=0 throughout.
- **Write then read back:** write 0xDEADBEEF at address 1024, then read at 1024 (default `WAIT_CYCLES`=4).
  - `ready` is low for exactly 5 cycles on each transaction.
  - `rd_data`=0xDEADBEEF in the read's DONE cycle.
- **Wrap-around:** write 0x11 at address 1024+4×64 (index wraps to 0), then read 1024 → 0x11. Read 1027 (misaligned) → 0x11.
- **Simultaneous enables:** write 0x55 to 1032, read it back, then assert `rd_en`=`wr_en`=1 at 1032 with 0xAA.
  - `rd_data` stays 0x55 through that transaction.
  - A later read of 1032 returns 0xAA.
- **Inputs changed mid-BUSY:** change `address`/`wr_data` during BUSY → the captured values are written; the changed values have no effect.
- **Reset mid-operation:** assert `rst` in the second BUSY cycle of a write of 0x77 to 1036.
  - State returns to IDLE and `ready`=1.
  - A read of 1036 returns the prior contents, not 0x77.
